div_seq: RTL and testbench
==========================

# div_seq

Iterative restoring divider: one quotient bit per enabled clock, start/valid handshake. It is the inverse companion to the pipelined multiplier in the DDC datapath. It serves gain normalisation and ratio computation where a few tens of cycles of latency are acceptable and area must stay small. Quotient, remainder and a divide-by-zero flag are registered and presented with a single-cycle valid strobe.

## Interface
- N_WIDTH, 16, dividend and quotient width (≥ 2)
- D_WIDTH, 8, divisor and remainder width (2 ≤ D_WIDTH ≤ N_WIDTH)

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- en_i  in  1  clock enable; low freezes every register, including outputs
- start_i  in  1  request; sampled only when idle and en_i=1
- n_i  in  N_WIDTH  dividend
- d_i  in  D_WIDTH  divisor
- busy_o  out  1  high while a division is in progress
- valid_o  out  1  result strobe
- q_o  out  N_WIDTH  quotient
- r_o  out  D_WIDTH  remainder
- dbz_o  out  1  divide-by-zero flag, qualified by valid_o and held with q_o

## Operation
- States: IDLE, CALC, DONE. All outputs reset to 0; state resets to IDLE.
- IDLE:
  - If start_i=1, latch operands. In signed mode, latch magnitudes plus sign bits.
  - Load bit counter with N_WIDTH-1. Go to CALC.
- CALC:
  - Each enabled edge shifts the next dividend bit into the partial remainder (D_WIDTH+1 bits).
  - Subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise set it to 0.
  - When the counter reaches 0, go to DONE.
- DONE:
  - Apply sign correction and register q_o, r_o, dbz_o.
  - Pulse valid_o. Go to IDLE.
- busy_o = 1 in CALC and DONE.
- start_i is ignored while busy_o=1; there is no queueing.
- Rounding: the quotient truncates toward zero. The remainder satisfies n = q·d + r, with |r| < |d|, and r takes the sign of the dividend.
- Divide by zero (d_i=0):
  - Runs the same number of cycles and sets dbz_o=1 and r_o=0.
  - Unsigned: q_o = all ones.
  - Signed: q_o = 2^(N_WIDTH-1)-1 if n ≥ 0, else -2^(N_WIDTH-1).
- Signed overflow (n = -2^(N_WIDTH-1), d = -1): q_o = 2^(N_WIDTH-1)-1, r_o = 0, dbz_o = 0.
- q_o, r_o and dbz_o hold their values until the next DONE or until reset.

## Timing
- Start accepted at edge E0.
  - CALC occupies edges E1..E_N_WIDTH.
  - Results and valid_o=1 are registered at edge E_N_WIDTH+1.
  - Latency: N_WIDTH+2 enabled cycles from the start cycle to the valid cycle (18 at defaults).
- valid_o is high for exactly one enabled cycle. If en_i is low during that cycle, valid_o stays high until the next enabled edge.
- The state is IDLE during the valid_o cycle, so a start_i in that same cycle is accepted. Back-to-back throughput is one result per N_WIDTH+2 cycles.
- en_i=0 stalls every register. Latency extends by the number of disabled cycles; results are unchanged.
- Reset asserted mid-operation:
  - Immediately forces IDLE and all outputs to 0.
  - The in-flight division is discarded and valid_o is never produced for it.
  - After reset is released, the block starts a new division only on a fresh start_i.

## Configuration
- Macro DIV_SEQ_SIGNED_EN.
- Defined: n_i, d_i, q_o and r_o are two's complement, with magnitude conversion on entry and sign correction in DONE. The signed divide-by-zero and overflow rules above apply.
- Undefined: all operands are unsigned, there is no sign logic, and the overflow rule does not exist. Latency is the same in both builds.

## Test plan
- Unsigned build, N=16/D=8: n=1000, d=7, start pulsed -> valid_o 18 cycles later with q=142, r=6, dbz=0. busy_o is high for the 17 cycles before it.
- Signed build: n=-1000, d=7 -> q=0xFF72 (-142), r=0xFA (-6). Then n=-32768, d=-1 -> q=0x7FFF, r=0, dbz=0.
- Divide by zero: n=1234, d=0 -> dbz_o=1, q=0xFFFF (unsigned build), r=0, latency still 18.
- Handshake:
  - start_i held high throughout a division -> no second operand capture until the valid cycle.
  - A start in the valid cycle is accepted, giving the next valid exactly 18 cycles later.
- en_i low for 5 cycles mid-CALC, with 1000/7 -> valid_o at 23 cycles, results identical to the first scenario.
- rst_i pulsed 8 cycles into CALC -> busy_o, valid_o, q_o, r_o, dbz_o are all 0 immediately, and no valid_o follows until a new start.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative restoring divider, one quotient bit per enabled clock.
// A start in IDLE latches the operands. CALC then resolves N_WIDTH quotient bits MSB first.
// DONE registers the quotient, remainder and divide-by-zero flag together with a one-cycle
// valid strobe.
// Handshake: start_i is sampled only when busy_o=0 and en_i=1. valid_o is a single
// enabled-cycle strobe, and q_o/r_o/dbz_o hold until the next result or reset.
// Optional build macro DIV_SEQ_SIGNED_EN selects two's complement operands. In that
// build the magnitudes are divided and the signs are restored in DONE.
// The FSM state is held in the enum register state_q.
module div_seq #(
    parameter int N_WIDTH = 16,
    parameter int D_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic [N_WIDTH-1:0] n_i,
    input  logic [D_WIDTH-1:0] d_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [N_WIDTH-1:0] q_o,
    output logic [D_WIDTH-1:0] r_o,
    output logic               dbz_o
);

    localparam int CNT_W = (N_WIDTH > 2) ? $clog2(N_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    // After N_WIDTH steps the register holds the quotient.
    logic [N_WIDTH-1:0] nq_q;
    // Partial remainder, D_WIDTH+1 bits.
    logic [D_WIDTH:0]   rem_q;
    logic [D_WIDTH-1:0] dv_q;
    logic               valid_q;
    logic               dbz_q;
    logic [N_WIDTH-1:0] q_q;
    logic [D_WIDTH-1:0] r_q;
`ifdef DIV_SEQ_SIGNED_EN
    logic               n_neg_q;
    logic               d_neg_q;
    logic [N_WIDTH-1:0] n_mag;
    logic [D_WIDTH-1:0] d_mag;
    localparam logic [N_WIDTH-1:0] Q_MAX = {1'b0, {(N_WIDTH-1){1'b1}}};
    localparam logic [N_WIDTH-1:0] Q_MIN = {1'b1, {(N_WIDTH-1){1'b0}}};
`endif

    // One restoring step: bring down the next dividend bit, then trial-subtract the divisor.
    logic [D_WIDTH+1:0] rem_shift;
    logic [D_WIDTH+1:0] trial;
    logic               fits;
    logic [D_WIDTH:0]   rem_d;
    logic [N_WIDTH-1:0] nq_d;

    // Combinational trial subtraction for the current CALC step
    always_comb begin
        rem_shift = {rem_q, nq_q[N_WIDTH-1]};
        trial     = rem_shift - {2'b00, dv_q};
        fits      = ~trial[D_WIDTH+1];
        rem_d     = fits ? trial[D_WIDTH:0] : rem_shift[D_WIDTH:0];
        nq_d      = {nq_q[N_WIDTH-2:0], fits};
    end

`ifdef DIV_SEQ_SIGNED_EN
    // Operand magnitudes for the signed build. The most negative value maps to 2^(W-1) unsigned.
    always_comb begin
        n_mag = n_i[N_WIDTH-1] ? (~n_i + 1'b1) : n_i;
        d_mag = d_i[D_WIDTH-1] ? (~d_i + 1'b1) : d_i;
    end
`endif

    // Sequencer, datapath and registered outputs; en_i=0 freezes everything
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nq_q    <= '0;
            rem_q   <= '0;
            dv_q    <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef DIV_SEQ_SIGNED_EN
            n_neg_q <= 1'b0;
            d_neg_q <= 1'b0;
`endif
        end else if (en_i) begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
`ifdef DIV_SEQ_SIGNED_EN
                        nq_q    <= n_mag;
                        dv_q    <= d_mag;
                        n_neg_q <= n_i[N_WIDTH-1];
                        d_neg_q <= d_i[D_WIDTH-1];
`else
                        nq_q    <= n_i;
                        dv_q    <= d_i;
`endif
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(N_WIDTH - 1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    nq_q  <= nq_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b1;
                    state_q <= IDLE;
`ifdef DIV_SEQ_SIGNED_EN
                    if (dv_q == '0) begin
                        q_q   <= n_neg_q ? Q_MIN : Q_MAX;
                        r_q   <= '0;
                        dbz_q <= 1'b1;
                    end else if (!(n_neg_q ^ d_neg_q) && nq_q[N_WIDTH-1]) begin
                        // Only -2^(N-1) / -1 yields a positive quotient magnitude that large.
                        q_q   <= Q_MAX;
                        r_q   <= '0;
                        dbz_q <= 1'b0;
                    end else begin
                        q_q   <= (n_neg_q ^ d_neg_q) ? (~nq_q + 1'b1) : nq_q;
                        r_q   <= n_neg_q ? (~rem_q[D_WIDTH-1:0] + 1'b1) : rem_q[D_WIDTH-1:0];
                        dbz_q <= 1'b0;
                    end
`else
                    if (dv_q == '0) begin
                        q_q   <= '1;
                        r_q   <= '0;
                        dbz_q <= 1'b1;
                    end else begin
                        q_q   <= nq_q;
                        r_q   <= rem_q[D_WIDTH-1:0];
                        dbz_q <= 1'b0;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = valid_q;
    assign q_o     = q_q;
    assign r_o     = r_q;
    assign dbz_o   = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against an arithmetic reference model.
module tb_div_seq;

    localparam int N = 16;
    localparam int D = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         start_i;
    logic [N-1:0] n_i;
    logic [D-1:0] d_i;
    logic         busy_o;
    logic         valid_o;
    logic [N-1:0] q_o;
    logic [D-1:0] r_o;
    logic         dbz_o;

    int n_cmp = 0;
    int n_mis = 0;

    div_seq #(.N_WIDTH(N), .D_WIDTH(D)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .start_i (start_i),
        .n_i     (n_i),
        .d_i     (d_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .q_o     (q_o),
        .r_o     (r_o),
        .dbz_o   (dbz_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: truncating division with the documented zero/overflow rules
    task automatic model(input logic [N-1:0] nn, input logic [D-1:0] dd,
                         output logic [N-1:0] q, output logic [D-1:0] r, output logic z);
        longint a, b, tq, tr;
`ifdef DIV_SEQ_SIGNED_EN
        a = longint'($signed(nn));
        b = longint'($signed(dd));
        z = 1'b0;
        if (b == 0) begin
            tq = (a >= 0) ? (64'sd1 <<< (N - 1)) - 1 : -(64'sd1 <<< (N - 1));
            tr = 0;
            z  = 1'b1;
        end else if (a == -(64'sd1 <<< (N - 1)) && b == -1) begin
            tq = (64'sd1 <<< (N - 1)) - 1;
            tr = 0;
        end else begin
            tq = a / b;
            tr = a % b;
        end
`else
        a = longint'(nn);
        b = longint'(dd);
        z = 1'b0;
        if (b == 0) begin
            tq = (64'sd1 <<< N) - 1;
            tr = 0;
            z  = 1'b1;
        end else begin
            tq = a / b;
            tr = a % b;
        end
`endif
        q = tq[N-1:0];
        r = tr[D-1:0];
    endtask

    // driver: present operands with start_i high (called just after a rising edge)
    task automatic drive_start(input logic [N-1:0] nn, input logic [D-1:0] dd);
        n_i     = nn;
        d_i     = dd;
        start_i = 1'b1;
    endtask

    // driver/monitor: count edges from the start cycle to the valid cycle
    task automatic wait_result(input bit hold, input int stall_at, input int stall_len,
                               output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk_i);
            #1;
            if (c == 1) begin
                if (!hold) start_i = 1'b0;
                n_i = N'($urandom);
                d_i = D'($urandom);
            end
            if (c == stall_at) en_i = 1'b0;
            if (c == stall_at + stall_len) en_i = 1'b1;
            if (valid_o) begin
                lat = c;
                break;
            end
            if (busy_o) busy_cnt++;
        end
        en_i = 1'b1;
    endtask

    task automatic run_one(input string tag, input logic [N-1:0] nn, input logic [D-1:0] dd,
                           input int stall_at, input int stall_len);
        logic [N-1:0] eq;
        logic [D-1:0] er;
        logic         ez;
        int           lat, bc;
        model(nn, dd, eq, er, ez);
        drive_start(nn, dd);
        wait_result(1'b0, stall_at, stall_len, lat, bc);
        check_eq({tag, "_lat"}, 64'(lat), 64'(N + 2 + stall_len));
        check_eq({tag, "_q"}, 64'(q_o), 64'(eq));
        check_eq({tag, "_r"}, 64'(r_o), 64'(er));
        check_eq({tag, "_dbz"}, 64'(dbz_o), 64'(ez));
    endtask

    initial begin
        logic [N-1:0] eq, n2;
        logic [D-1:0] er, d2;
        logic         ez;
        int           lat, bc;
        bit           seen_valid;

        rst_i   = 1'b1;
        en_i    = 1'b1;
        start_i = 1'b0;
        n_i     = '0;
        d_i     = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_q", 64'(q_o), 64'd0);
        check_eq("rst_r", 64'(r_o), 64'd0);
        check_eq("rst_dbz", 64'(dbz_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // 1000 / 7: latency 18, busy for 17 cycles before valid
        drive_start(16'd1000, 8'd7);
        wait_result(1'b0, 0, 0, lat, bc);
        check_eq("basic_lat", 64'(lat), 64'd18);
        check_eq("basic_busy_cycles", 64'(bc), 64'd17);
        check_eq("basic_q", 64'(q_o), 64'd142);
        check_eq("basic_r", 64'(r_o), 64'd6);
        check_eq("basic_dbz", 64'(dbz_o), 64'd0);
        @(posedge clk_i);
        #1;
        check_eq("valid_one_cycle", 64'(valid_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("q_hold", 64'(q_o), 64'd142);
        check_eq("r_hold", 64'(r_o), 64'd6);

        // divide by zero
        run_one("dbz", 16'd1234, 8'd0, 0, 0);
`ifndef DIV_SEQ_SIGNED_EN
        check_eq("dbz_q_ones", 64'(q_o), 64'hFFFF);
`else
        // signed vectors
        run_one("sneg", 16'hFC18, 8'd7, 0, 0);
        check_eq("sneg_q_const", 64'(q_o), 64'hFF72);
        check_eq("sneg_r_const", 64'(r_o), 64'hFA);
        run_one("sovf", 16'h8000, 8'hFF, 0, 0);
        check_eq("sovf_q_const", 64'(q_o), 64'h7FFF);
        run_one("sdbz_neg", 16'h8000, 8'd0, 0, 0);
`endif

        // en_i low for 5 cycles mid-CALC
        run_one("stall", 16'd1000, 8'd7, 5, 5);
        check_eq("stall_q_const", 64'(q_o), 64'd142);
        check_eq("stall_r_const", 64'(r_o), 64'd6);

        // start held high: operands captured once, then chained start in the valid cycle
        @(posedge clk_i);
        #1;
        model(16'd500, 8'd9, eq, er, ez);
        drive_start(16'd500, 8'd9);
        wait_result(1'b1, 0, 0, lat, bc);
        check_eq("hold_lat", 64'(lat), 64'd18);
        check_eq("hold_q", 64'(q_o), 64'(eq));
        check_eq("hold_r", 64'(r_o), 64'(er));
        n2 = n_i;
        d2 = d_i;
        model(n2, d2, eq, er, ez);
        wait_result(1'b0, 0, 0, lat, bc);
        check_eq("chain_lat", 64'(lat), 64'd18);
        check_eq("chain_q", 64'(q_o), 64'(eq));
        check_eq("chain_r", 64'(r_o), 64'(er));
        check_eq("chain_dbz", 64'(dbz_o), 64'(ez));

        // reset 8 cycles into CALC
        @(posedge clk_i);
        #1;
        drive_start(16'd1000, 8'd7);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check_eq("midrst_busy", 64'(busy_o), 64'd0);
        check_eq("midrst_valid", 64'(valid_o), 64'd0);
        check_eq("midrst_q", 64'(q_o), 64'd0);
        check_eq("midrst_r", 64'(r_o), 64'd0);
        check_eq("midrst_dbz", 64'(dbz_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o || busy_o) seen_valid = 1'b1;
        end
        check_eq("postrst_quiet", 64'(seen_valid), 64'd0);

        // randomized operands with occasional zero divisor and random stalls
        for (int i = 0; i < 25; i++) begin
            logic [N-1:0] rn;
            logic [D-1:0] rd;
            int           sl;
            rn = N'($urandom);
            rd = ($urandom_range(0, 4) == 0) ? '0 : D'($urandom);
            if ($urandom_range(0, 7) == 0) rn = {1'b1, {(N-1){1'b0}}};
            sl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            @(posedge clk_i);
            #1;
            run_one($sformatf("rand%0d", i), rn, rd, $urandom_range(2, 12), sl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
